// File: rtl/sound_pkg.sv
// ----------------------------------------------------------------------------
// sound_pkg
// Shared definitions for the sound block: register offsets of a channel's
// NRx0..NRx4 bank relative to its base address, the wave-channel volume
// codes, and the default register / wave RAM base addresses.
// ----------------------------------------------------------------------------
package sound_pkg;

  localparam logic [15:0] DEFAULT_REG_BASE  = 16'hFF1A;
  localparam logic [15:0] DEFAULT_WAVE_BASE = 16'hFF30;

  // Offsets of NRx0..NRx4 from the channel's register base.
  localparam logic [2:0] NRX0 = 3'd0;
  localparam logic [2:0] NRX1 = 3'd1;
  localparam logic [2:0] NRX2 = 3'd2;
  localparam logic [2:0] NRX3 = 3'd3;
  localparam logic [2:0] NRX4 = 3'd4;

  // Wave channel output level (NRx2 bits 6:5).
  typedef enum logic [1:0] {
    VOL_MUTE    = 2'd0,
    VOL_FULL    = 2'd1,
    VOL_HALF    = 2'd2,
    VOL_QUARTER = 2'd3
  } vol_e;

endpackage

// File: rtl/wave_ram.sv
// ----------------------------------------------------------------------------
// wave_ram
// Wavetable storage for one wave channel, organised as WAVE_DEPTH/SPB bytes
// (SPB = 8/SAMPLE_W samples per byte, most-significant sample first).
//
// Ports:
//   clk     - system clock
//   we      - CPU byte write enable (one write per clk)
//   addr    - CPU byte address
//   wdata   - CPU write data
//   rdata   - CPU read data (combinational)
//   sidx    - sample index for the playback read port
//   sample  - sample at sidx (combinational)
// ----------------------------------------------------------------------------
module wave_ram #(
  parameter int SAMPLE_W   = 4,
  parameter int WAVE_DEPTH = 32,
  localparam int SPB       = 8 / SAMPLE_W,
  localparam int NBYTES    = WAVE_DEPTH / SPB,
  localparam int BA_W      = (NBYTES > 1) ? $clog2(NBYTES) : 1,
  localparam int POS_W     = $clog2(WAVE_DEPTH)
) (
  input  logic                clk,
  input  logic                we,
  input  logic [BA_W-1:0]     addr,
  input  logic [7:0]          wdata,
  output logic [7:0]          rdata,
  input  logic [POS_W-1:0]    sidx,
  output logic [SAMPLE_W-1:0] sample
);

  logic [7:0] mem [NBYTES];
  logic [7:0] sbyte;
  int         sub;

  // NOTE: the array has no reset branch on purpose; wave contents survive a
  // channel reset, and leaving it out keeps this mappable onto a RAM macro.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

  // NOTE: every variable written here gets a value before any branch so the
  // block stays purely combinational (no inferred latch).
  always_comb begin
    sbyte  = mem[BA_W'(int'(sidx) / SPB)];
    sub    = int'(sidx) % SPB;
    // Sample 0 of a byte lives in its top bits.
    sample = SAMPLE_W'(sbyte >> ((SPB - 1 - sub) * SAMPLE_W));
  end

endmodule

// File: rtl/wave_channel.sv
// ----------------------------------------------------------------------------
// wave_channel
// Parametrised wavetable sound channel: NRx0..NRx4 register bank, frequency
// timer, length counter, volume shifter and its own wave RAM.
//
// Optional feature macro: WAVE_CHANNEL_RAM_LOCK_EN
//   defined   - while the channel is on, CPU wave RAM reads/writes are
//               redirected to the byte currently being played.
//   undefined - CPU wave RAM access always goes to the addressed byte.
//
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   tick       - frequency timer enable strobe
//   len_tick   - length counter strobe
//   master_en  - global sound enable; when low the channel bank is cleared
//   a, din     - CPU address / write data
//   dout       - CPU read data (combinational, 0 when idle or undecoded)
//   rd, wr     - CPU read / write strobes
//   out        - registered channel sample
//   on         - channel active flag
// ----------------------------------------------------------------------------
module wave_channel
  import sound_pkg::*;
#(
  parameter int          SAMPLE_W   = 4,
  parameter int          WAVE_DEPTH = 32,
  parameter int          FREQ_W     = 11,
  parameter int          LEN_W      = 8,
  parameter logic [15:0] REG_BASE   = DEFAULT_REG_BASE,
  parameter logic [15:0] WAVE_BASE  = DEFAULT_WAVE_BASE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                len_tick,
  input  logic                master_en,
  input  logic [15:0]         a,
  input  logic [7:0]          din,
  output logic [7:0]          dout,
  input  logic                rd,
  input  logic                wr,
  output logic [SAMPLE_W-1:0] out,
  output logic                on
);

  localparam int SPB    = 8 / SAMPLE_W;
  localparam int NBYTES = WAVE_DEPTH / SPB;
  localparam int BA_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int POS_W  = $clog2(WAVE_DEPTH);
  localparam int FH_W   = FREQ_W - 8;
  localparam logic [LEN_W:0] LEN_FULL = {1'b1, {LEN_W{1'b0}}};

  // Channel state
  logic                dac, dac_nx;
  vol_e                vol, vol_nx;
  logic [FREQ_W-1:0]   freq, freq_nx;
  logic                len_en, len_en_nx;
  logic [LEN_W:0]      len_cnt;
  logic [FREQ_W-1:0]   cnt;
  logic [POS_W-1:0]    pos, pos_inc;
  logic [SAMPLE_W-1:0] sample_buf, ram_sample;

  // Address decode
  logic [15:0] reg_off, wave_off;
  logic [2:0]  reg_sel;
  logic        reg_hit, wave_hit, reg_wr, trigger, len_step;

  assign reg_off  = a - REG_BASE;
  assign wave_off = a - WAVE_BASE;
  assign reg_hit  = (reg_off < 16'd5);
  assign wave_hit = (wave_off < 16'(NBYTES));
  assign reg_sel  = reg_off[2:0];
  assign reg_wr   = wr & master_en & reg_hit;
  assign trigger  = reg_wr & (reg_sel == NRX4) & din[7];
  assign len_step = len_tick & len_en & (len_cnt != '0);
  assign pos_inc  = pos + 1'b1;

  // Wave RAM CPU port
  logic [BA_W-1:0] ram_addr;
  logic [7:0]      ram_rdata;

`ifdef WAVE_CHANNEL_RAM_LOCK_EN
  // While playing, the CPU only ever sees the byte the channel is reading.
  assign ram_addr = on ? BA_W'(int'(pos) / SPB) : wave_off[BA_W-1:0];
`else
  assign ram_addr = wave_off[BA_W-1:0];
`endif

  wave_ram #(
    .SAMPLE_W   (SAMPLE_W),
    .WAVE_DEPTH (WAVE_DEPTH)
  ) u_ram (
    .clk    (clk),
    .we     (wr & wave_hit),
    .addr   (ram_addr),
    .wdata  (din),
    .rdata  (ram_rdata),
    .sidx   (pos_inc),
    .sample (ram_sample)
  );

  // Register bank next values; master_en low holds the bank cleared.
  always_comb begin
    dac_nx    = dac;
    vol_nx    = vol;
    freq_nx   = freq;
    len_en_nx = len_en;
    if (!master_en) begin
      dac_nx    = 1'b0;
      vol_nx    = VOL_MUTE;
      freq_nx   = '0;
      len_en_nx = 1'b0;
    end else if (reg_wr) begin
      case (reg_sel)
        NRX0: dac_nx = din[7];
        NRX2: vol_nx = vol_e'(din[6:5]);
        NRX3: freq_nx[7:0] = din;
        NRX4: begin
          len_en_nx           = din[6];
          freq_nx[FREQ_W-1:8] = din[FH_W-1:0];
        end
        default: ;
      endcase
    end
  end

  // NOTE: all state below is updated with non-blocking assignments so every
  // branch sees the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      dac        <= 1'b0;
      vol        <= VOL_MUTE;
      freq       <= '0;
      len_en     <= 1'b0;
      len_cnt    <= '0;
      cnt        <= '0;
      pos        <= '0;
      sample_buf <= '0;
      out        <= '0;
      on         <= 1'b0;
    end else begin
      dac    <= dac_nx;
      vol    <= vol_nx;
      freq   <= freq_nx;
      len_en <= len_en_nx;

      // Length counter; a trigger swallows a coincident len_tick.
      if (!master_en) begin
        len_cnt <= '0;
      end else if (reg_wr && (reg_sel == NRX1)) begin
        len_cnt <= LEN_FULL - (LEN_W + 1)'(din[LEN_W-1:0]);
      end else if (trigger) begin
        if (len_cnt == '0) len_cnt <= LEN_FULL;
      end else if (len_step) begin
        len_cnt <= len_cnt - 1'b1;
      end

      // Channel enable; turning the DAC off wins over everything else.
      if (!master_en || !dac_nx) begin
        on <= 1'b0;
      end else if (trigger) begin
        on <= 1'b1;
      end else if (len_step && (len_cnt == (LEN_W + 1)'(1))) begin
        on <= 1'b0;
      end

      // Frequency timer. Reload value ~freq equals 2^FREQ_W - freq - 1,
      // giving a period of 2^FREQ_W - freq ticks.
      if (trigger) begin
        cnt        <= ~freq_nx;
        pos        <= '0;
        sample_buf <= '0;
      end else if (tick && on) begin
        if (cnt == '0) begin
          cnt        <= ~freq;
          pos        <= pos_inc;
          sample_buf <= ram_sample;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end

      // Volume shifter
      if (on && dac) begin
        case (vol)
          VOL_MUTE:    out <= '0;
          VOL_FULL:    out <= sample_buf;
          VOL_HALF:    out <= sample_buf >> 1;
          VOL_QUARTER: out <= sample_buf >> 2;
          default:     out <= '0;
        endcase
      end else begin
        out <= '0;
      end
    end
  end

  // CPU readback with the unreadable bits forced high.
  always_comb begin
    dout = 8'h00;
    if (rd) begin
      if (reg_hit) begin
        case (reg_sel)
          NRX0:    dout = {dac, 7'h7F};
          NRX1:    dout = 8'hFF;
          NRX2:    dout = {1'b1, vol, 5'h1F};
          NRX3:    dout = 8'hFF;
          NRX4:    dout = {1'b1, len_en, 6'h3F};
          default: dout = 8'h00;
        endcase
      end else if (wave_hit) begin
        dout = ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_wave_channel.sv
// ----------------------------------------------------------------------------
// tb_wave_channel
// Self-checking bench for wave_channel (default parameters). Register
// readback is table driven; playback is compared against a model that
// derives the expected sample from the tick count since the last trigger.
// ----------------------------------------------------------------------------
module tb_wave_channel;

  localparam logic [15:0] R0 = 16'hFF1A;
  localparam logic [15:0] R1 = 16'hFF1B;
  localparam logic [15:0] R2 = 16'hFF1C;
  localparam logic [15:0] R3 = 16'hFF1D;
  localparam logic [15:0] R4 = 16'hFF1E;
  localparam logic [15:0] WB = 16'hFF30;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        len_tick = 1'b0;
  logic        master_en = 1'b1;
  logic [15:0] a = 16'h0000;
  logic [7:0]  din = 8'h00;
  logic [7:0]  dout;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [3:0]  out;
  logic        on;

  int checks = 0;
  int errors = 0;

  // Model state
  logic [7:0] ram_m [16];
  int         period  = 1;
  int         cur_vol = 1;
  int         n_ticks = 0;

  wave_channel dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .len_tick  (len_tick),
    .master_en (master_en),
    .a         (a),
    .din       (din),
    .dout      (dout),
    .rd        (rd),
    .wr        (wr),
    .out       (out),
    .on        (on)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        men;
    logic [15:0] waddr;
    logic [7:0]  wdata;
    logic [15:0] raddr;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic cpu_write(input logic [15:0] addr, input logic [7:0] data);
    a   = addr;
    din = data;
    wr  = 1'b1;
    @(negedge clk);
    wr  = 1'b0;
  endtask

  task automatic cpu_read(input logic [15:0] addr, output logic [7:0] data);
    a  = addr;
    rd = 1'b1;
    #1;
    data = dout;
    rd = 1'b0;
  endtask

  task automatic ram_fill(input int idx, input logic [7:0] data);
    ram_m[idx] = data;
    cpu_write(WB + 16'(idx), data);
  endtask

  // Trigger with freq = 0x7xx; period follows from the low byte written.
  task automatic trigger_note(input logic [7:0] nr4, input logic [7:0] lo);
    cpu_write(R4, nr4);
    period  = 2048 - {nr4[2:0], lo};
    n_ticks = 0;
  endtask

  function automatic logic [3:0] model_out(input int n);
    int         idx;
    logic [7:0] b;
    logic [3:0] s;
    s = 4'h0;
    if (n >= period) begin
      idx = (n / period) % 32;
      b   = ram_m[idx / 2];
      s   = (idx % 2 == 1) ? b[3:0] : b[7:4];
    end
    if (cur_vol == 0) return 4'h0;
    return s >> (cur_vol - 1);
  endfunction

  task automatic play(input int cycles, input int tick_pct, input string name);
    logic t;
    for (int i = 0; i < cycles; i++) begin
      t    = ($urandom_range(99) < tick_pct);
      tick = t;
      @(negedge clk);
      tick = 1'b0;
      check(name, out, model_out(n_ticks));
      if (t) n_ticks++;
    end
    check({name, "_on"}, on, 1'b1);
  endtask

  task automatic len_pulse();
    len_tick = 1'b1;
    @(negedge clk);
    len_tick = 1'b0;
  endtask

  initial begin
    logic [7:0] rdv;
    logic [7:0] exp_b;
    int         p;
    logic [3:0] lo;

    vecs[0]  = '{1'b1, R0, 8'h80, R0, 8'hFF};
    vecs[1]  = '{1'b1, R0, 8'h00, R0, 8'h7F};
    vecs[2]  = '{1'b1, R1, 8'h3C, R1, 8'hFF};
    vecs[3]  = '{1'b1, R2, 8'h40, R2, 8'hDF};
    vecs[4]  = '{1'b1, R2, 8'h60, R2, 8'hFF};
    vecs[5]  = '{1'b1, R3, 8'h12, R3, 8'hFF};
    vecs[6]  = '{1'b1, R4, 8'h40, R4, 8'hFF};
    vecs[7]  = '{1'b1, R4, 8'h00, R4, 8'hBF};
    vecs[8]  = '{1'b1, 16'hFF1F, 8'h55, 16'hFF1F, 8'h00};
    vecs[9]  = '{1'b1, 16'hFF30, 8'h5A, 16'hFF30, 8'h5A};
    vecs[10] = '{1'b1, 16'hFF3F, 8'hC3, 16'hFF3F, 8'hC3};
    vecs[11] = '{1'b1, 16'hFF40, 8'h77, 16'hFF40, 8'h00};
    vecs[12] = '{1'b1, R2, 8'h20, R2, 8'hBF};
    vecs[13] = '{1'b0, R2, 8'h60, R2, 8'h9F};
    vecs[14] = '{1'b0, 16'hFF31, 8'hA5, 16'hFF31, 8'hA5};
    vecs[15] = '{1'b1, R0, 8'h80, R0, 8'hFF};

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_out", out, 4'h0);
    check("rst_on", on, 1'b0);
    cpu_read(R0, rdv); check("rst_nr0", rdv, 8'h7F);
    cpu_read(R4, rdv); check("rst_nr4", rdv, 8'hBF);
    a = R0; rd = 1'b0; #1;
    check("rd_low_dout", dout, 8'h00);

    // Register / RAM readback table
    for (int i = 0; i < 16; i++) begin
      master_en = vecs[i].men;
      cpu_write(vecs[i].waddr, vecs[i].wdata);
      cpu_read(vecs[i].raddr, rdv);
      check($sformatf("vec%0d", i), rdv, vecs[i].exp);
    end
    master_en = 1'b1;

    // Playback at one sample per tick
    ram_m[0]  = 8'h01; ram_m[1]  = 8'h23; ram_m[2]  = 8'h45; ram_m[3]  = 8'h67;
    ram_m[4]  = 8'h89; ram_m[5]  = 8'hAB; ram_m[6]  = 8'hCD; ram_m[7]  = 8'hEF;
    ram_m[8]  = 8'hED; ram_m[9]  = 8'hCB; ram_m[10] = 8'hA9; ram_m[11] = 8'h87;
    ram_m[12] = 8'h65; ram_m[13] = 8'h43; ram_m[14] = 8'h21; ram_m[15] = 8'h00;
    for (int i = 0; i < 16; i++) ram_fill(i, ram_m[i]);
    cpu_write(R0, 8'h80);
    cpu_write(R2, 8'h20); cur_vol = 1;
    cpu_write(R3, 8'hFF);
    trigger_note(8'h87, 8'hFF);
    check("trig_on", on, 1'b1);
    play(70, 100, "full");

    // Volume shifts and mute
    cpu_write(R2, 8'h40); cur_vol = 2;
    trigger_note(8'h87, 8'hFF);
    play(40, 100, "half");
    cpu_write(R2, 8'h60); cur_vol = 3;
    trigger_note(8'h87, 8'hFF);
    play(40, 100, "quarter");
    cpu_write(R2, 8'h00); cur_vol = 0;
    trigger_note(8'h87, 8'hFF);
    play(20, 100, "mute");

    // Length counter expiry
    cpu_write(R2, 8'h20); cur_vol = 1;
    cpu_write(R1, 8'hFE);
    trigger_note(8'hC7, 8'hFF);
    len_pulse(); check("len1_on", on, 1'b1);
    len_pulse(); check("len2_on", on, 1'b0);
    @(negedge clk); check("len2_out", out, 4'h0);
    len_pulse(); check("len3_on", on, 1'b0);

    // Trigger coinciding with tick and len_tick
    cpu_write(R1, 8'hFE);
    cpu_write(R3, 8'hF0);
    trigger_note(8'hC7, 8'hF0);
    play(20, 100, "pre_coinc");
    a = R4; din = 8'hC7; wr = 1'b1; tick = 1'b1; len_tick = 1'b1;
    @(negedge clk);
    wr = 1'b0; tick = 1'b0; len_tick = 1'b0;
    n_ticks = 0;
    play(40, 100, "coinc");
    len_pulse(); check("coinc_len1_on", on, 1'b1);
    len_pulse(); check("coinc_len2_on", on, 1'b0);

    // DAC off, retrigger with DAC off, reset mid-note
    trigger_note(8'h87, 8'hF0);
    play(10, 100, "dac_pre");
    cpu_write(R0, 8'h00); check("dac_off_on", on, 1'b0);
    cpu_write(R4, 8'h87); check("dac0_trig_on", on, 1'b0);
    cpu_write(R0, 8'h80);
    trigger_note(8'h87, 8'hF0);
    play(25, 100, "pre_rst");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_out", out, 4'h0);
    check("midrst_on", on, 1'b0);
    cpu_read(R0, rdv); check("midrst_nr0", rdv, 8'h7F);
    cpu_read(R2, rdv); check("midrst_nr2", rdv, 8'h9F);
    for (int i = 0; i < 16; i++) begin
      cpu_read(WB + 16'(i), rdv);
      check($sformatf("ram_keep%0d", i), rdv, ram_m[i]);
    end

    // Wave RAM read while playing
    @(negedge clk);
    cpu_write(R0, 8'h80);
    cpu_write(R2, 8'h20); cur_vol = 1;
    cpu_write(R3, 8'hF0);
    trigger_note(8'h87, 8'hF0);
    play(70, 100, "lock_pre");
    p = (n_ticks / period) % 32;
`ifdef WAVE_CHANNEL_RAM_LOCK_EN
    exp_b = ram_m[p / 2];
`else
    exp_b = 8'hAB;
`endif
    cpu_read(16'hFF35, rdv); check("ram_while_on", rdv, exp_b);

    // Randomised playback against the model
    for (int r = 0; r < 6; r++) begin
      cpu_write(R0, 8'h00);
      for (int i = 0; i < 16; i++) ram_fill(i, 8'($urandom));
      cpu_write(R0, 8'h80);
      cur_vol = $urandom_range(3);
      cpu_write(R2, 8'(cur_vol << 5));
      lo = 4'($urandom_range(15));
      cpu_write(R3, {4'hF, lo});
      trigger_note(8'h87, {4'hF, lo});
      play(150, 60, $sformatf("rand%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
